rgmii_tx_framer: RTL
====================

# rgmii_tx_framer

Single-clock Ethernet transmit framer on the ETH_REFCLK domain that sits in front of the RGMII DDR output stage and drives its SDR TX_DATA/TX_DV inputs. It accepts a payload byte stream over a valid/ready/last handshake and emits complete frames: preamble, SFD, payload, zero padding to a minimum length, optional FCS, and an enforced inter-frame gap. Underflow is detected and signalled mid-frame, and good and aborted frames are counted.

## Interface
- PREAMBLE_LEN, 7: number of 0x55 bytes before the SFD (1..15).
- MIN_FRAME, 60: payload+pad byte minimum before FCS; 0 disables padding (0..2047).
- IFG_BYTES, 12: minimum TX_DV-low cycles between frames (1..255).
- ETH_REFCLK  in  1  125 MHz clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- S_DATA  in  8  payload byte.
- S_VALID  in  1  S_DATA valid.
- S_LAST  in  1  marks last payload byte.
- S_READY  out  1  framer accepts byte this cycle.
- TX_DATA  out  8  SDR byte to RGMII stage.
- TX_DV  out  1  transmit enable.
- TX_ER  out  1  transmit error (underflow abort).
- BUSY  out  1  state != IDLE.
- FRAME_COUNT  out  16  good frames sent, wraps.
- ERR_COUNT  out  8  aborted frames, saturates at 255.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE: S_READY=0. S_VALID=1 → PREAMBLE. The byte is not consumed.
- PREAMBLE: TX_DATA=0x55, TX_DV=1 for PREAMBLE_LEN cycles → SFD.
- SFD: TX_DATA=0xD5 for one cycle → DATA.
- S_READY=1 while TX_DATA shows the SFD or a data byte and S_LAST has not yet been accepted. A byte accepted in cycle n appears on TX_DATA in cycle n+1.
- The payload counter (11 bits, saturating at 2047) counts accepted bytes.
- When S_LAST is accepted:
  - if count < MIN_FRAME → PAD;
  - else → FCS if FCS is enabled, otherwise → IFG.
- PAD: TX_DATA=0x00 until payload+pad equals MIN_FRAME → FCS or IFG.
- Underflow: S_READY=1 and S_VALID=0 in the same cycle.
  - Next cycle: TX_DATA=0x00, TX_DV=1, TX_ER=1 for exactly one cycle.
  - Then TX_DV=0 and state DRAIN.
  - DRAIN: S_READY=1, bytes are discarded until S_LAST is accepted → IFG.
  - ERR_COUNT increments; FRAME_COUNT does not; no FCS is sent.
  - If S_LAST arrives with S_VALID in the underflow cycle itself, it is not accepted; DRAIN still waits for it.
- IFG: TX_DV=0, TX_DATA=0x00, S_READY=0 for IFG_BYTES cycles.
  - If S_VALID=1 in the final IFG cycle → PREAMBLE directly, otherwise → IDLE.
- FRAME_COUNT increments in the cycle the last byte of a good frame (FCS, pad or data) is output.

## Timing
- All outputs are registered except S_READY, which is combinational from state/flags.
- Reset: TX_DATA=0x00, TX_DV=0, TX_ER=0, BUSY=0, S_READY=0, FRAME_COUNT=0, ERR_COUNT=0, state IDLE.
- Reset mid-frame truncates the frame at the next edge with no TX_ER. Reset has priority over all events.
- Latency: S_VALID sampled high in IDLE at cycle 0 → first 0x55 at cycle 1.
  - SFD at cycle PREAMBLE_LEN+1.
  - First payload byte at PREAMBLE_LEN+2.
- Back-to-back frames have exactly IFG_BYTES TX_DV-low cycles between them.
- TX_DV is continuous from the first preamble byte to the last FCS byte; no gaps.

## Configuration
- FCS_APPEND_EN defined:
  - CRC-32 is computed over payload+pad: reflected poly 0x04C11DB7, init 0xFFFFFFFF, final complement.
  - It is appended as 4 bytes, least significant byte first, in state FCS.
- FCS_APPEND_EN undefined:
  - FCS state and CRC logic are absent.
  - The frame ends after the last payload/pad byte; upstream supplies the FCS.

## Test plan
- Defaults, FCS on, 1-byte payload 0xAB at cycle 0:
  - 0x55 on cycles 1–7, 0xD5 on 8, 0xAB on 9, 0x00 on 10–68, FCS on 69–72.
  - TX_DV low 73–84; FRAME_COUNT=1.
- MIN_FRAME=0, FCS on, payload ASCII "123456789" → FCS bytes 0x26,0x39,0xF4,0xCB; no pad bytes.
- Two 64-byte frames offered back-to-back (S_VALID held high) → exactly 12 TX_DV-low cycles between the last FCS byte and the next 0x55.
- S_VALID dropped after byte 10 of 100:
  - one cycle TX_DV=1, TX_ER=1, TX_DATA=0x00, then TX_DV=0;
  - remaining bytes drained until S_LAST; ERR_COUNT=1, FRAME_COUNT unchanged.
- RESET pulsed during PAD → next cycle TX_DV=0, counters 0, BUSY=0; a new frame then starts cleanly with 0x55.
- FCS off, 64-byte payload → TX_DV high for exactly 72 cycles (7+1+64).

Source files
------------

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer: Ethernet TX framer feeding the RGMII SDR data/enable inputs.
// Define FCS_APPEND_EN to generate and append the CRC-32 FCS in hardware.
module rgmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        ETH_REFCLK,
    input  logic        RESET,
    input  logic [7:0]  S_DATA,
    input  logic        S_VALID,
    input  logic        S_LAST,
    output logic        S_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_DV,
    output logic        TX_ER,
    output logic        BUSY,
    output logic [15:0] FRAME_COUNT,
    output logic [7:0]  ERR_COUNT
);
    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG
    } state_t;

    localparam logic [7:0]  PRE_L = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_L = 8'(IFG_BYTES);
    localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
`ifdef FCS_APPEND_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    // state names what TX_DATA shows this cycle; done marks the last byte on the wire
    state_t      state, nxt;
    logic [10:0] cnt, cnt_n, cnt_inc;
    logic [7:0]  cyc, cyc_n;
    logic        done, done_n;
    logic [7:0]  tx_n;
    logic        dv_n, er_n;
    logic        fc_inc, ec_inc;
    logic        start, take, tail;

`ifdef FCS_APPEND_EN
    logic [31:0] crc, crc_n, crc_sh;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_sh = ~crc >> {cyc[1:0], 3'b000};

    always_ff @(posedge ETH_REFCLK) begin
        if (RESET) crc <= '1;
        else       crc <= crc_n;
    end
`endif

    assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign S_READY = (state == SFD) || (state == DRAIN) ||
                     (state == DATA && !done);

    always_comb begin
        nxt    = state;
        tx_n   = 8'h00;
        dv_n   = 1'b0;
        er_n   = 1'b0;
        cnt_n  = cnt;
        cyc_n  = cyc;
        done_n = done;
        fc_inc = 1'b0;
        ec_inc = 1'b0;
        start  = 1'b0;
        take   = 1'b0;
        tail   = 1'b0;
`ifdef FCS_APPEND_EN
        crc_n  = crc;
`endif
        unique case (state)
            IDLE: start = S_VALID;
            PREAMBLE: begin
                dv_n = 1'b1;
                if (cyc == PRE_L) begin
                    nxt  = SFD;
                    tx_n = 8'hD5;
                end else begin
                    tx_n  = 8'h55;
                    cyc_n = cyc + 8'd1;
                end
            end
            SFD: take = 1'b1;
            DATA: begin
                if (done) tail = 1'b1;
                else      take = 1'b1;
            end
            PAD: tail = 1'b1;
`ifdef FCS_APPEND_EN
            FCS: begin
                if (cyc == 8'd4) begin
                    nxt   = IFG;
                    cyc_n = 8'd1;
                end else begin
                    tx_n   = crc_sh[7:0];
                    dv_n   = 1'b1;
                    cyc_n  = cyc + 8'd1;
                    fc_inc = (cyc == 8'd3);
                end
            end
`endif
            DRAIN: begin
                if (S_VALID && S_LAST) begin
                    nxt   = IFG;
                    cyc_n = 8'd1;
                end
            end
            IFG: begin
                if (cyc == IFG_L) begin
                    if (S_VALID) start = 1'b1;
                    else         nxt   = IDLE;
                end else begin
                    cyc_n = cyc + 8'd1;
                end
            end
            default: nxt = IDLE;
        endcase

        if (start) begin
            nxt    = PREAMBLE;
            tx_n   = 8'h55;
            dv_n   = 1'b1;
            cyc_n  = 8'd1;
            cnt_n  = '0;
            done_n = 1'b0;
`ifdef FCS_APPEND_EN
            crc_n  = '1;
`endif
        end

        if (take) begin
            if (S_VALID) begin
                nxt    = DATA;
                tx_n   = S_DATA;
                dv_n   = 1'b1;
                cnt_n  = cnt_inc;
                done_n = S_LAST;
                fc_inc = !FCS_ON && S_LAST && (cnt_inc >= MIN_L);
`ifdef FCS_APPEND_EN
                crc_n  = crc_byte(crc, S_DATA);
`endif
            end else begin
                nxt    = DRAIN;
                dv_n   = 1'b1;
                er_n   = 1'b1;
                ec_inc = 1'b1;
            end
        end

        if (tail) begin
            if (cnt < MIN_L) begin
                nxt    = PAD;
                dv_n   = 1'b1;
                cnt_n  = cnt_inc;
                fc_inc = !FCS_ON && (cnt_inc == MIN_L);
`ifdef FCS_APPEND_EN
                crc_n  = crc_byte(crc, 8'h00);
`endif
            end else begin
`ifdef FCS_APPEND_EN
                nxt  = FCS;
                tx_n = ~crc[7:0];
                dv_n = 1'b1;
`else
                nxt  = IFG;
`endif
                cyc_n = 8'd1;
            end
        end
    end

    always_ff @(posedge ETH_REFCLK) begin
        if (RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            cyc         <= '0;
            done        <= 1'b0;
            TX_DATA     <= 8'h00;
            TX_DV       <= 1'b0;
            TX_ER       <= 1'b0;
            BUSY        <= 1'b0;
            FRAME_COUNT <= '0;
            ERR_COUNT   <= '0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_n;
            cyc     <= cyc_n;
            done    <= done_n;
            TX_DATA <= tx_n;
            TX_DV   <= dv_n;
            TX_ER   <= er_n;
            BUSY    <= (nxt != IDLE);
            if (fc_inc)
                FRAME_COUNT <= FRAME_COUNT + 16'd1;
            if (ec_inc && ERR_COUNT != 8'hFF)
                ERR_COUNT <= ERR_COUNT + 8'd1;
        end
    end

endmodule
